// File: rtl/sigmoid_alu_pkg.sv
// Shared types and widths for the sigmoid ALU sum sequencer slice.
package sigmoid_alu_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;
    localparam int CNT_W     = 8;
    localparam int ACC_W     = 18;
    localparam int SUM_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/sigmoid_alu_sum_sequencer_if.sv
// Job / beat / result handshake bundle between producer, consumer and sequencer.
interface sigmoid_alu_sum_sequencer_if;
    import sigmoid_alu_pkg::*;

    logic                            start;
    logic [CNT_W-1:0]                group_count;
    logic                            abort;
    logic                            in_valid;
    logic [NUM_LANES*LANE_W-1:0]     in_data;
    logic                            in_ready;
    logic                            out_ready;
    logic                            out_valid;
    logic [ACC_W-1:0]                sum_out;
    logic                            busy;

    modport master (
        output start, group_count, abort, in_valid, in_data, out_ready,
        input  in_ready, out_valid, sum_out, busy
    );

    modport slave (
        input  start, group_count, abort, in_valid, in_data, out_ready,
        output in_ready, out_valid, sum_out, busy
    );

endinterface

// File: rtl/sigmoid_ALU_4_way_adder.sv
// Signed sum of the four 8-bit lanes of one beat into a 10-bit result.
module sigmoid_ALU_4_way_adder
    import sigmoid_alu_pkg::*;
#(
    parameter int LANES = NUM_LANES
) (
    input  logic [LANES*LANE_W-1:0] i_data,
    output logic [SUM_W-1:0]        o_sum
);

    logic [LANE_W-1:0] w_lane;
    logic [SUM_W-1:0]  w_sum;

    // Sign-extend each lane to the result width and add them up; 10 bits
    // holds 4 * -128 = -512 down to 4 * 127 = 508 without wrapping.
    always_comb begin
        w_lane = '0;
        w_sum  = '0;
        for (int i = 0; i < LANES; i++) begin
            w_lane = i_data[i*LANE_W +: LANE_W];
            w_sum  = w_sum + {{(SUM_W-LANE_W){w_lane[LANE_W-1]}}, w_lane};
        end
    end

    assign o_sum = w_sum;

endmodule

// File: rtl/sigmoid_alu_sum_sequencer.sv
// Accumulates group_count beats of four signed lanes into an 18-bit job sum
// and presents it with a valid/ready handshake until the consumer takes it.
module sigmoid_alu_sum_sequencer
    import sigmoid_alu_pkg::*;
#(
    parameter int LANES = NUM_LANES
) (
    input  logic                     clk,
    input  logic                     n_rst,
    sigmoid_alu_sum_sequencer_if.slave bus
);

    seq_state_t         r_state;
    seq_state_t         w_next;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_remaining;
    logic [SUM_W-1:0]   w_beat_sum;
    logic [ACC_W-1:0]   w_beat_ext;
    logic               w_xfer;

    sigmoid_ALU_4_way_adder #(
        .LANES (LANES)
    ) u_adder (
        .i_data (bus.in_data),
        .o_sum  (w_beat_sum)
    );

    assign w_beat_ext = {{(ACC_W-SUM_W){w_beat_sum[SUM_W-1]}}, w_beat_sum};
    assign w_xfer     = (r_state == ST_ACCUM) && bus.in_valid;

    // State register; reset drops any job in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; abort overrides everything, and DONE->IDLE never
    // looks at start so a new job waits at least one cycle in IDLE.
    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_next = (bus.group_count != '0) ? ST_ACCUM : ST_DONE;
                    end
                end
                ST_ACCUM: begin
                    if (w_xfer && (r_remaining == CNT_W'(1))) begin
                        w_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        w_next = ST_IDLE;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Accumulator and beat counter: loaded on start, stepped per transfer,
    // frozen in DONE so the result stays stable until it is taken.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_acc       <= '0;
            r_remaining <= '0;
        end else if (bus.abort) begin
            r_acc       <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_acc       <= '0;
                        r_remaining <= bus.group_count;
                    end
                end
                ST_ACCUM: begin
                    if (w_xfer) begin
                        r_acc       <= r_acc + w_beat_ext;
                        r_remaining <= r_remaining - CNT_W'(1);
                    end
                end
                default: begin
                    r_acc       <= r_acc;
                    r_remaining <= r_remaining;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_ACCUM);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.sum_out   = r_acc;

endmodule

// File: tb/tb_sigmoid_alu_sum_sequencer.sv
// Self-checking bench for the sum sequencer: directed corner jobs plus
// randomized jobs scored against a plain-arithmetic reference sum.
module tb_sigmoid_alu_sum_sequencer;

    logic clk;
    logic n_rst;

    sigmoid_alu_sum_sequencer_if vif();

    sigmoid_alu_sum_sequencer #(
        .LANES (4)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (vif)
    );

    int checkCount;
    int passCount;
    logic [31:0] beatQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: total of every lane of every queued beat, as signed bytes.
    function automatic int model_sum();
        int   s;
        logic [31:0] w;
        byte  b;
        s = 0;
        foreach (beatQ[i]) begin
            w = beatQ[i];
            for (int l = 0; l < 4; l++) begin
                b = w[l*8 +: 8];
                s = s + int'(b);
            end
        end
        return s;
    endfunction

    task automatic start_job(input logic [7:0] count);
        @(negedge clk);
        vif.start       = 1'b1;
        vif.group_count = count;
        @(negedge clk);
        vif.start       = 1'b0;
        vif.group_count = $urandom;
    endtask

    // Presents beatQ in order, optionally with random idle gaps, and returns
    // at the negedge after the final transfer edge with in_valid low.
    task automatic drive_beats(input bit gaps, output bit ok);
        int idx;
        int guard;
        idx   = 0;
        guard = 0;
        while (idx < beatQ.size() && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                vif.in_valid = 1'b0;
                vif.in_data  = $urandom;
            end else begin
                vif.in_valid = 1'b1;
                vif.in_data  = beatQ[idx];
                if (vif.in_ready) idx++;
            end
        end
        @(negedge clk);
        vif.in_valid = 1'b0;
        vif.in_data  = $urandom;
        ok = (idx == beatQ.size());
    endtask

    task automatic ack_result();
        vif.out_ready = 1'b1;
        @(negedge clk);
        vif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        checkCount++;
        if (vif.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", vif.out_valid);
        else passCount++;
        checkCount++;
        if (vif.in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %b want 0", vif.in_ready);
        else passCount++;
        checkCount++;
        if (vif.busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", vif.busy);
        else passCount++;
        checkCount++;
        if (vif.sum_out !== 18'd0) $display("[TB] FAIL reset_sum got %0h want 0", vif.sum_out);
        else passCount++;
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        beatQ = {32'h04030201, 32'hFFFFFFFF};
        start_job(8'd2);
        checkCount++;
        if (vif.in_ready !== 1'b1) $display("[TB] FAIL basic_in_ready got %b want 1", vif.in_ready);
        else passCount++;
        drive_beats(1'b0, ok);
        checkCount++;
        if (!ok) $display("[TB] FAIL basic_timeout got %0d want %0d beats", 0, beatQ.size());
        else passCount++;
        checkCount++;
        if (vif.out_valid !== 1'b1) $display("[TB] FAIL basic_latency got out_valid=%b want 1", vif.out_valid);
        else passCount++;
        checkCount++;
        if ($signed(vif.sum_out) !== 18'sd6) $display("[TB] FAIL basic_sum got %0d want 6", $signed(vif.sum_out));
        else passCount++;
        ack_result();
        checkCount++;
        if (vif.out_valid !== 1'b0 || vif.busy !== 1'b0)
            $display("[TB] FAIL basic_ack got valid=%b busy=%b want 0/0", vif.out_valid, vif.busy);
        else passCount++;
    endtask

    task automatic test_extremes();
        bit ok;
        logic [31:0] pat[2];
        logic [17:0] want[2];
        pat[0]  = 32'h80808080;
        pat[1]  = 32'h7F7F7F7F;
        want[0] = 18'h20200;
        want[1] = 18'd129540;
        for (int p = 0; p < 2; p++) begin
            beatQ.delete();
            for (int i = 0; i < 255; i++) beatQ.push_back(pat[p]);
            start_job(8'd255);
            drive_beats(1'b0, ok);
            checkCount++;
            if (!ok || vif.out_valid !== 1'b1)
                $display("[TB] FAIL extreme_done got ok=%b valid=%b want 1/1", ok, vif.out_valid);
            else passCount++;
            checkCount++;
            if (vif.sum_out !== want[p])
                $display("[TB] FAIL extreme_sum got %0h want %0h", vif.sum_out, want[p]);
            else passCount++;
            ack_result();
        end
    endtask

    task automatic test_zero_groups();
        start_job(8'd0);
        checkCount++;
        if (vif.out_valid !== 1'b1 || vif.in_ready !== 1'b0)
            $display("[TB] FAIL zero_done got valid=%b ready=%b want 1/0", vif.out_valid, vif.in_ready);
        else passCount++;
        checkCount++;
        if (vif.sum_out !== 18'd0) $display("[TB] FAIL zero_sum got %0h want 0", vif.sum_out);
        else passCount++;
        ack_result();
    endtask

    task automatic test_stalls();
        bit ok;
        int n;
        logic [17:0] exp;
        for (int job = 0; job < 3; job++) begin
            n = $urandom_range(1, 20);
            beatQ.delete();
            for (int i = 0; i < n; i++) beatQ.push_back($urandom);
            exp = 18'(model_sum());
            start_job(8'(n));
            drive_beats(1'b1, ok);
            checkCount++;
            if (!ok) $display("[TB] FAIL stall_timeout got partial want %0d beats", n);
            else passCount++;
            for (int c = 0; c < 10; c++) begin
                vif.start       = (c == 4);
                vif.group_count = 8'd3;
                checkCount++;
                if (vif.out_valid !== 1'b1 || vif.sum_out !== exp)
                    $display("[TB] FAIL stall_hold got valid=%b sum=%0h want 1/%0h", vif.out_valid, vif.sum_out, exp);
                else passCount++;
                @(negedge clk);
            end
            vif.start = 1'b1;
            ack_result();
            vif.start = 1'b0;
            checkCount++;
            if (vif.busy !== 1'b0 || vif.out_valid !== 1'b0)
                $display("[TB] FAIL stall_start_on_ack got busy=%b valid=%b want 0/0", vif.busy, vif.out_valid);
            else passCount++;
        end
    endtask

    task automatic test_abort();
        bit ok;
        beatQ.delete();
        for (int i = 0; i < 3; i++) beatQ.push_back($urandom);
        start_job(8'd5);
        drive_beats(1'b0, ok);
        vif.abort = 1'b1;
        @(negedge clk);
        vif.abort = 1'b0;
        checkCount++;
        if (vif.busy !== 1'b0 || vif.out_valid !== 1'b0 || vif.sum_out !== 18'd0)
            $display("[TB] FAIL abort_clear got busy=%b valid=%b sum=%0h want 0/0/0", vif.busy, vif.out_valid, vif.sum_out);
        else passCount++;
        beatQ = {32'h05050505};
        start_job(8'd1);
        drive_beats(1'b0, ok);
        checkCount++;
        if (!ok || vif.out_valid !== 1'b1 || $signed(vif.sum_out) !== 18'sd20)
            $display("[TB] FAIL abort_next_sum got valid=%b sum=%0d want 1/20", vif.out_valid, $signed(vif.sum_out));
        else passCount++;
        ack_result();
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        beatQ.delete();
        for (int i = 0; i < 3; i++) beatQ.push_back($urandom);
        start_job(8'd5);
        drive_beats(1'b0, ok);
        n_rst = 1'b0;
        #1;
        checkCount++;
        if (vif.busy !== 1'b0 || vif.sum_out !== 18'd0)
            $display("[TB] FAIL rst_async got busy=%b sum=%0h want 0/0", vif.busy, vif.sum_out);
        else passCount++;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        checkCount++;
        if (vif.out_valid !== 1'b0 || vif.busy !== 1'b0)
            $display("[TB] FAIL rst_no_result got valid=%b busy=%b want 0/0", vif.out_valid, vif.busy);
        else passCount++;
        beatQ = {32'h05050505};
        start_job(8'd1);
        drive_beats(1'b0, ok);
        checkCount++;
        if (!ok || vif.out_valid !== 1'b1 || $signed(vif.sum_out) !== 18'sd20)
            $display("[TB] FAIL rst_next_sum got valid=%b sum=%0d want 1/20", vif.out_valid, $signed(vif.sum_out));
        else passCount++;
        ack_result();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        logic [17:0] exp;
        for (int job = 0; job < 8; job++) begin
            n = $urandom_range(0, 8);
            beatQ.delete();
            for (int i = 0; i < n; i++) beatQ.push_back($urandom);
            exp = 18'(model_sum());
            start_job(8'(n));
            drive_beats(1'b0, ok);
            checkCount++;
            if (!ok || vif.out_valid !== 1'b1 || vif.sum_out !== exp)
                $display("[TB] FAIL b2b_job%0d got valid=%b sum=%0h want 1/%0h", job, vif.out_valid, vif.sum_out, exp);
            else passCount++;
            ack_result();
        end
    endtask

    initial begin
        checkCount          = 0;
        passCount           = 0;
        n_rst               = 1'b0;
        vif.start           = 1'b0;
        vif.group_count     = 8'd0;
        vif.abort           = 1'b0;
        vif.in_valid        = 1'b0;
        vif.in_data         = 32'd0;
        vif.out_ready       = 1'b0;
        test_reset();
        test_basic();
        test_extremes();
        test_zero_groups();
        test_stalls();
        test_abort();
        test_reset_mid_job();
        test_back_to_back();
        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
